// File: rtl/decode_forward_stage.sv
// decode_forward_stage: decodes one 32-bit instruction per cycle and resolves
// its source operands. Each operand comes from the youngest matching forwarding
// channel, or from the register file if no channel matches. The decoded result
// is held in a single output register slot.
//
// Ports
//   clk, rstN             clock, asynchronous active-low reset
//   flush                 drops the held and the incoming instruction
//   inValid / inReady     upstream handshake (inReady is combinational)
//   inInstruction, inPc   instruction word and its PC
//   inException           0 none, 1 instr, 2 syscall, 3 usage fault
//   regFileReadRegTag     source tags sent to the register file
//   regFileReadValue      register file read data, one XLEN lane per port
//   fwdValid/RegTag/Value forwarding channels, index 0 youngest
//   exLoadPending/RegTag  load currently in EX (load-use interlock)
//   outValid / outReady   downstream handshake
//   outClass ... outPc    registered decode results
//   stallCount            saturating count of hazard bubbles
module decode_forward_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_FWD     = 2,
  parameter int unsigned NUM_READ    = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     flush,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [31:0]              inInstruction,
  input  logic [XLEN-1:0]          inPc,
  input  logic [1:0]               inException,
  output logic [4*NUM_READ-1:0]    regFileReadRegTag,
  input  logic [XLEN*NUM_READ-1:0] regFileReadValue,
  input  logic [NUM_FWD-1:0]       fwdValid,
  input  logic [4*NUM_FWD-1:0]     fwdRegTag,
  input  logic [XLEN*NUM_FWD-1:0]  fwdValue,
  input  logic                     exLoadPending,
  input  logic [3:0]               exLoadRegTag,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [2:0]               outClass,
  output logic [1:0]               outException,
  output logic [3:0]               outDstRegTag,
  output logic [XLEN*NUM_READ-1:0] outSrcValue,
  output logic [XLEN-1:0]          outImm,
  output logic [XLEN-1:0]          outPc,
  output logic [STALL_CNT_W-1:0]   stallCount
);

  typedef enum logic [2:0] {
    ClsTransfer = 3'd0,
    ClsDataProc = 3'd1,
    ClsBranch   = 3'd2,
    ClsMoveImm  = 3'd3,
    ClsInstrExc = 3'd4,
    ClsSyscall  = 3'd5
  } instr_class_e;

  // Source tag field of read port idx; ports beyond the four encoded fields read R0.
  function automatic logic [3:0] tag_field(input int unsigned idx, input logic [31:0] instr);
    logic [3:0] t;
    case (idx)
      0:       t = instr[27:24];
      1:       t = instr[23:20];
      2:       t = instr[3:0];
      3:       t = instr[13:10];
      default: t = 4'h0;
    endcase
    return t;
  endfunction

  instr_class_e            cls;
  logic [3:0]              used4;
  logic [NUM_READ-1:0]     src_used;
  logic [NUM_READ-1:0]     load_match;
  logic [3:0]              src_tag [NUM_READ];
  logic [XLEN-1:0]         src_val [NUM_READ];
  logic [XLEN*NUM_READ-1:0] src_flat;
  logic [XLEN-1:0]         imm;
  logic [3:0]              dst_tag;
  logic [1:0]              exc;
  logic                    hazard;
  logic                    slot_free;
  logic                    accept;

  logic                     valid_q;
  logic [2:0]               class_q;
  logic [1:0]               exc_q;
  logic [3:0]               dst_q;
  logic [XLEN*NUM_READ-1:0] src_q;
  logic [XLEN-1:0]          imm_q;
  logic [XLEN-1:0]          pc_q;
  logic [STALL_CNT_W-1:0]   stall_q;

  // Class decode from the top nibble.
  always_comb begin
    cls = ClsTransfer;
    casez (inInstruction[31:28])
      4'b00??: cls = ClsTransfer;
      4'b01??: cls = ClsDataProc;
      4'b10??: cls = ClsBranch;
      4'b110?: cls = ClsMoveImm;
      4'b1110: cls = ClsInstrExc;
      default: cls = ClsSyscall;
    endcase
  end

  // Which of the four encoded source fields the class actually reads.
  always_comb begin
    used4 = 4'b0000;
    case (cls)
      ClsTransfer: used4 = 4'b0111;
      ClsDataProc: used4 = {~inInstruction[29], ~inInstruction[28], 1'b1, 1'b0};
      ClsBranch:   used4 = {1'b0, ~inInstruction[28], 2'b00};
      default:     used4 = 4'b0000;
    endcase
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_src
    assign src_tag[i] = tag_field(i, inInstruction);
    assign regFileReadRegTag[i*4 +: 4] = src_tag[i];

    if (i < 4) begin : g_used
      assign src_used[i] = used4[i];
    end else begin : g_unused
      assign src_used[i] = 1'b0;
    end

    assign load_match[i] = src_used[i] && (src_tag[i] == exLoadRegTag);

    // Walk channels oldest to youngest so the lowest matching index wins.
    always_comb begin
      src_val[i] = regFileReadValue[i*XLEN +: XLEN];
      for (int f = int'(NUM_FWD) - 1; f >= 0; f--) begin
        if (fwdValid[f] && (fwdRegTag[f*4 +: 4] == src_tag[i])) begin
          src_val[i] = fwdValue[f*XLEN +: XLEN];
        end
      end
      if (!src_used[i] || (src_tag[i] == 4'h0)) begin
        src_val[i] = '0;
      end
    end

    assign src_flat[i*XLEN +: XLEN] = src_val[i];
  end

  // Immediate formation.
  always_comb begin
    imm = '0;
    case (cls)
      ClsDataProc: imm = {{(XLEN-10){inInstruction[9]}}, inInstruction[9:0]};
      ClsBranch:   imm = {{(XLEN-24){inInstruction[23]}}, inInstruction[23:0]};
      ClsMoveImm:  imm = {{(XLEN-24){inInstruction[28]}}, inInstruction[23:0]};
      default:     imm = '0;
    endcase
  end

  // Destination: branch-and-link writes the link register R14.
  always_comb begin
    dst_tag = 4'h0;
    case (cls)
      ClsTransfer, ClsDataProc, ClsMoveImm: dst_tag = inInstruction[27:24];
      ClsBranch:   dst_tag = inInstruction[29] ? 4'hE : 4'h0;
      default:     dst_tag = 4'h0;
    endcase
  end

  // An upstream exception outranks one raised by decode.
  always_comb begin
    if (inException != 2'd0) begin
      exc = inException;
    end else if (cls == ClsInstrExc) begin
      exc = 2'd1;
    end else if (cls == ClsSyscall) begin
      exc = 2'd2;
    end else begin
      exc = 2'd0;
    end
  end

  // Load-use interlock; an excepting instruction never reads its operands.
  assign hazard = inValid && exLoadPending && (exLoadRegTag != 4'h0) &&
                  (inException == 2'd0) && (|load_match);

  assign slot_free = !valid_q || outReady;
  assign inReady   = slot_free && !hazard && !flush;
  assign accept    = inValid && inReady;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid_q <= 1'b0;
      class_q <= 3'd0;
      exc_q   <= 2'd0;
      dst_q   <= 4'h0;
      src_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      stall_q <= '0;
    end else if (flush) begin
      // Flush wins over hazard and load and never counts as a bubble.
      valid_q <= 1'b0;
    end else if (slot_free) begin
      valid_q <= accept;
      if (accept) begin
        class_q <= cls;
        exc_q   <= exc;
        pc_q    <= inPc;
        if (exc != 2'd0) begin
          dst_q <= 4'h0;
          src_q <= '0;
          imm_q <= '0;
        end else begin
          dst_q <= dst_tag;
          src_q <= src_flat;
          imm_q <= imm;
        end
      end
      if (hazard && (stall_q != {STALL_CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign outValid     = valid_q;
  assign outClass     = class_q;
  assign outException = exc_q;
  assign outDstRegTag = dst_q;
  assign outSrcValue  = src_q;
  assign outImm       = imm_q;
  assign outPc        = pc_q;
  assign stallCount   = stall_q;

endmodule

// File: tb/tb_decode_forward_stage.sv
module tb_decode_forward_stage;

  localparam int unsigned XLEN = 32;

  logic         clk;
  logic         rstN;
  logic         flush;
  logic         inValid;
  logic         inReady;
  logic [31:0]  inInstruction;
  logic [31:0]  inPc;
  logic [1:0]   inException;
  logic [15:0]  regFileReadRegTag;
  logic [127:0] regFileReadValue;
  logic [1:0]   fwdValid;
  logic [7:0]   fwdRegTag;
  logic [63:0]  fwdValue;
  logic         exLoadPending;
  logic [3:0]   exLoadRegTag;
  logic         outValid;
  logic         outReady;
  logic [2:0]   outClass;
  logic [1:0]   outException;
  logic [3:0]   outDstRegTag;
  logic [127:0] outSrcValue;
  logic [31:0]  outImm;
  logic [31:0]  outPc;
  logic [15:0]  stallCount;

  int n_tests;
  int n_fail;

  decode_forward_stage #(
    .XLEN(32), .NUM_FWD(2), .NUM_READ(4), .STALL_CNT_W(16)
  ) dut (
    .clk(clk), .rstN(rstN), .flush(flush),
    .inValid(inValid), .inReady(inReady),
    .inInstruction(inInstruction), .inPc(inPc), .inException(inException),
    .regFileReadRegTag(regFileReadRegTag), .regFileReadValue(regFileReadValue),
    .fwdValid(fwdValid), .fwdRegTag(fwdRegTag), .fwdValue(fwdValue),
    .exLoadPending(exLoadPending), .exLoadRegTag(exLoadRegTag),
    .outValid(outValid), .outReady(outReady),
    .outClass(outClass), .outException(outException), .outDstRegTag(outDstRegTag),
    .outSrcValue(outSrcValue), .outImm(outImm), .outPc(outPc), .stallCount(stallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_tests++; if (outValid !== 1'b0) begin n_fail++;
      $display("FAIL rst_valid: got %0b want 0", outValid); end
    n_tests++; if (stallCount !== 16'd0) begin n_fail++;
      $display("FAIL rst_stall: got %0d want 0", stallCount); end
    n_tests++; if (outSrcValue !== 128'd0 || outImm !== 32'd0 || outPc !== 32'd0) begin n_fail++;
      $display("FAIL rst_data: got src %h imm %h pc %h want 0", outSrcValue, outImm, outPc); end
    n_tests++; if (outClass !== 3'd0 || outException !== 2'd0 || outDstRegTag !== 4'd0) begin
      n_fail++; $display("FAIL rst_ctrl: got cls %0d exc %0d dst %0d want 0", outClass,
                         outException, outDstRegTag); end
  endtask

  task automatic test_forward_priority();
    inValid = 1'b1; inInstruction = 32'h4123_0C05; inPc = 32'h100; outReady = 1'b1;
    fwdValid = 2'b11; fwdRegTag = {4'd2, 4'd2}; fwdValue = {32'hBBBB, 32'hAAAA};
    #1;
    n_tests++; if (regFileReadRegTag !== 16'h3521) begin n_fail++;
      $display("FAIL fwd_rftag: got %h want 3521", regFileReadRegTag); end
    n_tests++; if (inReady !== 1'b1) begin n_fail++;
      $display("FAIL fwd_inready: got %0b want 1", inReady); end
    tick();
    inValid = 1'b0;
    n_tests++; if (outValid !== 1'b1) begin n_fail++;
      $display("FAIL fwd_valid: got %0b want 1", outValid); end
    n_tests++; if (outSrcValue[63:32] !== 32'hAAAA) begin n_fail++;
      $display("FAIL fwd_priority: got %h want 0000aaaa", outSrcValue[63:32]); end
    n_tests++; if (outSrcValue[31:0] !== 32'h0 || outSrcValue[95:64] !== 32'h1002 ||
                   outSrcValue[127:96] !== 32'h1003) begin n_fail++;
      $display("FAIL fwd_other_src: got %h want 00001003_00001002_xxxx_00000000", outSrcValue); end
    n_tests++; if (outClass !== 3'd1 || outImm !== 32'd5 || outDstRegTag !== 4'd1 ||
                   outPc !== 32'h100 || outException !== 2'd0) begin n_fail++;
      $display("FAIL fwd_decode: got cls %0d imm %h dst %0d pc %h exc %0d want 1 5 1 100 0",
               outClass, outImm, outDstRegTag, outPc, outException); end
  endtask

  task automatic test_r0();
    // Same instruction, a valid channel carrying tag 0.
    inValid = 1'b1; inInstruction = 32'h4123_0C05; inPc = 32'h104;
    fwdValid = 2'b01; fwdRegTag = {4'd9, 4'd0}; fwdValue = {32'h0, 32'h1234};
    tick();
    n_tests++; if (outSrcValue[31:0] !== 32'h0) begin n_fail++;
      $display("FAIL r0_dataproc: got %h want 0", outSrcValue[31:0]); end
    // Transfer reading R0 on port 0 while a channel offers tag 0.
    inInstruction = 32'h0020_0001; inPc = 32'h108;
    fwdValid = 2'b11; fwdRegTag = {4'd1, 4'd0}; fwdValue = {32'h5555, 32'h1234};
    tick();
    inValid = 1'b0;
    n_tests++; if (outSrcValue !== {32'h0, 32'h5555, 32'h1001, 32'h0}) begin n_fail++;
      $display("FAIL r0_transfer: got %h want 0,5555,1001,0", outSrcValue); end
    n_tests++; if (outClass !== 3'd0 || outDstRegTag !== 4'd0 || outImm !== 32'd0) begin
      n_fail++; $display("FAIL r0_decode: got cls %0d dst %0d imm %h want 0 0 0",
                         outClass, outDstRegTag, outImm); end
  endtask

  task automatic test_load_use();
    fwdValid = 2'b00;
    inValid = 1'b1; inInstruction = 32'h4123_0C05; inPc = 32'h10C;
    exLoadPending = 1'b1; exLoadRegTag = 4'd1;   // tag 1 sits on an unused port
    #1;
    n_tests++; if (inReady !== 1'b1) begin n_fail++;
      $display("FAIL lu_unused_port: got inReady %0b want 1", inReady); end
    exLoadRegTag = 4'd2;
    #1;
    n_tests++; if (inReady !== 1'b0) begin n_fail++;
      $display("FAIL lu_inready: got %0b want 0", inReady); end
    tick();
    n_tests++; if (outValid !== 1'b0 || stallCount !== 16'd1) begin n_fail++;
      $display("FAIL lu_bubble: got valid %0b stall %0d want 0 1", outValid, stallCount); end
    exLoadPending = 1'b0;
    #1;
    n_tests++; if (inReady !== 1'b1) begin n_fail++;
      $display("FAIL lu_release: got inReady %0b want 1", inReady); end
    tick();
    inValid = 1'b0;
    n_tests++; if (outValid !== 1'b1 || outPc !== 32'h10C || outSrcValue[63:32] !== 32'h1001 ||
                   stallCount !== 16'd1) begin n_fail++;
      $display("FAIL lu_accept: got valid %0b pc %h src1 %h stall %0d want 1 10c 1001 1",
               outValid, outPc, outSrcValue[63:32], stallCount); end
  endtask

  task automatic test_backpressure();
    inValid = 1'b1; inInstruction = 32'h0020_0001; inPc = 32'h200; outReady = 1'b1;
    tick();
    inInstruction = 32'hD3AB_CDEF; inPc = 32'h204; outReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++; if (inReady !== 1'b0) begin n_fail++;
        $display("FAIL bp_inready[%0d]: got %0b want 0", c, inReady); end
      tick();
      n_tests++; if (outValid !== 1'b1 || outPc !== 32'h200 || outClass !== 3'd0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid %0b pc %h cls %0d want 1 200 0",
                           c, outValid, outPc, outClass); end
    end
    outReady = 1'b1;
    #1;
    n_tests++; if (inReady !== 1'b1) begin n_fail++;
      $display("FAIL bp_release: got inReady %0b want 1", inReady); end
    tick();
    inValid = 1'b0;
    n_tests++; if (outPc !== 32'h204 || outClass !== 3'd3 || outImm !== 32'hFFAB_CDEF ||
                   outDstRegTag !== 4'd3 || outSrcValue !== 128'd0) begin n_fail++;
      $display("FAIL bp_next: got pc %h cls %0d imm %h dst %0d src %h want 204 3 ffabcdef 3 0",
               outPc, outClass, outImm, outDstRegTag, outSrcValue); end
  endtask

  task automatic test_flush();
    inValid = 1'b1; inInstruction = 32'h0000_0000; inPc = 32'h300; outReady = 1'b1;
    tick();
    outReady = 1'b0; flush = 1'b1;
    inInstruction = 32'h4123_0C05; exLoadPending = 1'b1; exLoadRegTag = 4'd2;
    #1;
    n_tests++; if (inReady !== 1'b0) begin n_fail++;
      $display("FAIL fl_inready: got %0b want 0", inReady); end
    tick();
    n_tests++; if (outValid !== 1'b0 || stallCount !== 16'd1) begin n_fail++;
      $display("FAIL fl_clear: got valid %0b stall %0d want 0 1", outValid, stallCount); end
    // Slot now free with a live hazard: flush still wins, no bubble counted.
    tick();
    n_tests++; if (outValid !== 1'b0 || stallCount !== 16'd1) begin n_fail++;
      $display("FAIL fl_hazard: got valid %0b stall %0d want 0 1", outValid, stallCount); end
    flush = 1'b0; exLoadPending = 1'b0; inValid = 1'b0; outReady = 1'b1;
  endtask

  task automatic test_exception();
    inValid = 1'b1; inInstruction = 32'hF000_0000; inException = 2'd3; inPc = 32'h400;
    tick();
    n_tests++; if (outValid !== 1'b1 || outException !== 2'd3 || outImm !== 32'd0 ||
                   outClass !== 3'd5) begin n_fail++;
      $display("FAIL exc_usage: got valid %0b exc %0d imm %h cls %0d want 1 3 0 5",
               outValid, outException, outImm, outClass); end
    inInstruction = 32'hE123_4567; inException = 2'd0;
    tick();
    n_tests++; if (outException !== 2'd1 || outClass !== 3'd4 || outDstRegTag !== 4'd0) begin
      n_fail++; $display("FAIL exc_instr: got exc %0d cls %0d dst %0d want 1 4 0",
                         outException, outClass, outDstRegTag); end
    // Upstream exception masks operands and suppresses the load interlock.
    inInstruction = 32'h4123_0C05; inException = 2'd2;
    exLoadPending = 1'b1; exLoadRegTag = 4'd2;
    #1;
    n_tests++; if (inReady !== 1'b1) begin n_fail++;
      $display("FAIL exc_no_hazard: got inReady %0b want 1", inReady); end
    tick();
    n_tests++; if (outException !== 2'd2 || outSrcValue !== 128'd0 || outImm !== 32'd0 ||
                   outDstRegTag !== 4'd0 || outClass !== 3'd1) begin n_fail++;
      $display("FAIL exc_zero: got exc %0d src %h imm %h dst %0d cls %0d want 2 0 0 0 1",
               outException, outSrcValue, outImm, outDstRegTag, outClass); end
    inException = 2'd0; exLoadPending = 1'b0; inValid = 1'b0;
  endtask

  task automatic test_back_to_back();
    inValid = 1'b1; inInstruction = 32'hA080_0007; inPc = 32'h500;
    tick();
    inInstruction = 32'h7000_0200; inPc = 32'h504;
    n_tests++; if (outValid !== 1'b1 || outClass !== 3'd2 || outImm !== 32'hFF80_0007 ||
                   outDstRegTag !== 4'hE || outSrcValue[95:64] !== 32'h1002) begin n_fail++;
      $display("FAIL b2b_branch: got v %0b cls %0d imm %h dst %h src2 %h want 1 2 ff800007 e 1002",
               outValid, outClass, outImm, outDstRegTag, outSrcValue[95:64]); end
    tick();
    inValid = 1'b0;
    n_tests++; if (outValid !== 1'b1 || outPc !== 32'h504 || outImm !== 32'hFFFF_FE00 ||
                   outDstRegTag !== 4'd0 || outSrcValue !== {96'd0, 32'h0}) begin n_fail++;
      $display("FAIL b2b_dataproc: got v %0b pc %h imm %h dst %0d src %h want 1 504 fffffe00 0 0",
               outValid, outPc, outImm, outDstRegTag, outSrcValue); end
    tick();
    n_tests++; if (outValid !== 1'b0) begin n_fail++;
      $display("FAIL b2b_drain: got %0b want 0", outValid); end
  endtask

  task automatic test_async_reset();
    inValid = 1'b1; inInstruction = 32'h0020_0001; inPc = 32'h600;
    tick();
    #2 rstN = 1'b0;
    #1;
    n_tests++; if (outValid !== 1'b0 || stallCount !== 16'd0 || outPc !== 32'd0 ||
                   outSrcValue !== 128'd0) begin n_fail++;
      $display("FAIL areset: got valid %0b stall %0d pc %h src %h want 0 0 0 0",
               outValid, stallCount, outPc, outSrcValue); end
    inValid = 1'b0;
    tick();
    rstN = 1'b1;
    tick();
    n_tests++; if (outValid !== 1'b0) begin n_fail++;
      $display("FAIL areset_idle: got %0b want 0", outValid); end
    inValid = 1'b1; inPc = 32'h700;
    tick();
    inValid = 1'b0;
    n_tests++; if (outValid !== 1'b1 || outPc !== 32'h700) begin n_fail++;
      $display("FAIL areset_first: got valid %0b pc %h want 1 700", outValid, outPc); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rstN = 1'b0; flush = 1'b0; inValid = 1'b0; inInstruction = 32'h0; inPc = 32'h0;
    inException = 2'd0; fwdValid = 2'b00; fwdRegTag = 8'h0; fwdValue = 64'h0;
    exLoadPending = 1'b0; exLoadRegTag = 4'h0; outReady = 1'b1;
    regFileReadValue = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
    tick();
    tick();
    test_reset();
    rstN = 1'b1;
    test_forward_priority();
    test_r0();
    test_load_use();
    test_backpressure();
    test_flush();
    test_exception();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_forward_stage.md
DECODE_FORWARD_STAGE -- requirements
Module: decode_forward_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NUM_FWD, default 2, number of forwarding channels; index 0 is youngest and highest priority.
REQ-003 SHALL have parameter NUM_READ, default 4, number of source operand ports.
REQ-004 SHALL have parameter STALL_CNT_W, default 16, width of the stall counter.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rstN, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port flush, input, 1, discards the held and incoming instruction.
REQ-008 SHALL have ports inValid (input, 1) and inReady (output, 1), the upstream handshake.
REQ-009 SHALL have ports inInstruction (input, 32), inPc (input, XLEN) and inException (input, 2; 0 none, 1 instr, 2 syscall, 3 usage fault).
REQ-010 SHALL have ports regFileReadRegTag (output, 4*NUM_READ) and regFileReadValue (input, XLEN*NUM_READ), the register file read ports.
REQ-011 SHALL have ports fwdValid (input, NUM_FWD), fwdRegTag (input, 4*NUM_FWD) and fwdValue (input, XLEN*NUM_FWD), the forwarding channels.
REQ-012 SHALL have ports exLoadPending (input, 1) and exLoadRegTag (input, 4), the load in the EX stage.
REQ-013 SHALL have ports outValid (output, 1) and outReady (input, 1), the downstream handshake.
REQ-014 SHALL have registered outputs outClass (3), outException (2), outDstRegTag (4), outSrcValue (XLEN*NUM_READ), outImm (XLEN) and outPc (XLEN).
REQ-015 SHALL have port stallCount, output, STALL_CNT_W, saturating count of hazard bubbles.

Function
REQ-016 SHALL decode the class from bits [31:28]: 00xx transfer=0, 01xx dataproc=1, 10xx branch=2, 110x moveimm=3, 1110 instr-exception=4, 1111 syscall=5.
REQ-017 SHALL take source tags from bits [27:24], [23:20], [3:0] and [13:10] as ports 0-3; ports at index 4 and above SHALL drive tag 0.
REQ-018 SHALL mark sources as used per class: transfer 0,1,2; dataproc 1 always, 2 when bit28=0, 3 when bit29=0; branch 2 when bit28=0; all other classes none.
REQ-019 SHALL resolve each source value as: tag 0 gives 0; else the lowest-index channel with fwdValid=1 and a matching tag; else regFileReadValue; unused sources SHALL give 0.
REQ-020 SHALL form outImm as: dataproc sign-extend [9:0]; branch sign-extend [23:0]; moveimm {8 copies of bit28, [23:0]}; otherwise 0.
REQ-021 SHALL set outDstRegTag to [27:24] for transfer, dataproc and moveimm; to 4'hE when a branch has bit29=1; otherwise 0.
REQ-022 SHALL set outException to inException when that is nonzero; else 1 for class 4, 2 for class 5, else 0. When nonzero, outSrcValue, outImm and outDstRegTag SHALL be 0.
REQ-023 SHALL define slotFree = !outValid || outReady.
REQ-024 SHALL raise hazard when inValid=1, exLoadPending=1, exLoadRegTag is nonzero, it equals any used source tag, and inException=0.
REQ-025 SHALL drive inReady = slotFree && !hazard && !flush, combinationally.
REQ-026 SHALL, when slotFree is true, load the output register on the edge with outValid <= inValid && !hazard && !flush.
REQ-027 SHALL, when slotFree is false, hold all outputs stable.
REQ-028 SHALL make a hazard with slotFree true insert exactly one bubble per cycle (outValid=0) and increment stallCount, saturating at all-ones.
REQ-029 SHALL, on flush, clear outValid on the next edge regardless of outReady; flush SHALL have priority over hazard and load, and SHALL NOT increment stallCount.
REQ-030 SHALL give latency of one cycle from the inValid&&inReady edge to outValid.
REQ-031 SHALL sustain throughput of one instruction per cycle when there is no hazard and outReady=1.

Reset
REQ-032 SHALL, while rstN=0, asynchronously force outValid=0 and stallCount=0, and all registered data outputs to 0.
REQ-033 SHALL discard an instruction held at reset; the first acceptance after rstN rises SHALL occur on the first edge with inValid=1.

Verification
REQ-034 SHALL be verified for forward priority: instr 0x4123_0C05 (dataproc), fwd0 and fwd1 both tag 2 with values 0xAAAA/0xBBBB -> outSrcValue[1]=0xAAAA.
REQ-035 SHALL be verified for R0: the same instruction with tag 0 on a valid channel carrying 0x1234 -> the port-0 source=0.
REQ-036 SHALL be verified for load-use: exLoadPending=1, exLoadRegTag=2 and an instruction using tag 2 -> inReady=0, one bubble, stallCount=1; drop exLoadPending -> accepted next cycle.
REQ-037 SHALL be verified for backpressure: outReady=0 for 3 cycles with outValid=1 -> outputs stable and inReady=0; outReady=1 -> the next instruction is loaded.
REQ-038 SHALL be verified for flush: flush with outValid=1 and outReady=0 -> outValid=0 next cycle and stallCount unchanged.
REQ-039 SHALL be verified for exception override: inException=3 with instr 0xF000_0000 -> outException=3, outImm=0.
